csi2_pkt_framer: RTL and testbench

Converts the timing-generator output (vsync/hsync/4-pixel-per-clock 64-bit words with valid and data type) into a CSI-2-style packet stream: Frame Start and Frame End short packets, plus one long packet per active line with header, payload and CRC-16 trailer. It sits directly downstream of the video sync generator (`top`) and upstream of the PHY lane distributor; `img_save` can tap its input in parallel. Real-time stream, no backpressure.

---
 rtl/csi2_pkt_framer.sv | 160 ++++++++++++++++
 tb/tb_csi2_pkt_framer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_pkt_framer.sv
// Frames the 4-pixel-per-clock video stream into CSI-2 style packets: FS/FE short
// packets on vsync edges and one header/payload/CRC-16 long packet per active line.
module csi2_pkt_framer #(
  parameter int         HACT      = 1920,
  parameter int         BPP_BYTES = 2,
  parameter logic [1:0] VC        = 2'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [63:0] i_pixel_data,
  input  logic        i_pixel_valid,
  input  logic [5:0]  i_data_type,
  output logic [63:0] o_pkt_data,
  output logic        o_pkt_valid,
  output logic        o_pkt_sop,
  output logic        o_pkt_eop,
  output logic [15:0] o_frame_num,
  output logic        o_err_len,
  output logic        o_err_ovr
);

  localparam logic [15:0] WC    = 16'(HACT * BPP_BYTES);
  localparam logic [15:0] WORDS = 16'(HACT / 4);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_TRAIL, S_DROP} state_t;

  state_t           state_reg;
  logic             vsync_reg, valid_reg;
  logic             fs_pend_reg, fe_pend_reg;
  logic [63:0]      pipe_reg;
  logic [15:0]      crc_reg, count_reg;
  logic             hsync_unused;
  logic             vs_rise, vs_fall, line_rise, line_fall, line_ok, line_out;
  logic             fs_req, fe_req;
  logic [15:0]      frame_next;
  logic [8:0][15:0] crc_chain;

  function automatic logic [63:0] short_word(input logic [5:0] dt, input logic [15:0] field);
    logic [7:0] di;
    di = {VC, dt};
    return {32'd0, di ^ field[7:0] ^ field[15:8], field, di};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  assign hsync_unused = i_hsync;
  assign vs_rise      = i_vsync & ~vsync_reg;
  assign vs_fall      = ~i_vsync & vsync_reg;
  assign line_rise    = i_pixel_valid & ~valid_reg;
  assign line_fall    = ~i_pixel_valid & valid_reg;
  assign line_ok      = line_rise & i_vsync & (state_reg == S_IDLE);
  // Any cycle carrying header, payload or trailer blocks the short packets.
  assign line_out     = (state_reg == S_LINE) | (state_reg == S_TRAIL) | line_ok;
  assign fs_req       = fs_pend_reg | vs_rise;
  assign fe_req       = fe_pend_reg | vs_fall;
  assign frame_next   = (o_frame_num == 16'hFFFF) ? 16'd1 : o_frame_num + 16'd1;

  // CRC over the word leaving the payload stage, bytes [7:0] first.
  assign crc_chain[0] = crc_reg;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc
      assign crc_chain[gi+1] = crc_byte(crc_chain[gi], pipe_reg[8*gi +: 8]);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      vsync_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      fs_pend_reg <= 1'b0;
      fe_pend_reg <= 1'b0;
      pipe_reg    <= '0;
      crc_reg     <= 16'hFFFF;
      count_reg   <= '0;
      o_pkt_data  <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt_sop   <= 1'b0;
      o_pkt_eop   <= 1'b0;
      o_frame_num <= '0;
      o_err_len   <= 1'b0;
      o_err_ovr   <= 1'b0;
    end else begin
      vsync_reg   <= i_vsync;
      valid_reg   <= i_pixel_valid;
      fs_pend_reg <= fs_req;
      fe_pend_reg <= fe_req;
      o_pkt_data  <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt_sop   <= 1'b0;
      o_pkt_eop   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (line_ok) begin
            state_reg   <= S_LINE;
            o_pkt_data  <= short_word(i_data_type, WC);
            o_pkt_valid <= 1'b1;
            o_pkt_sop   <= 1'b1;
            pipe_reg    <= i_pixel_data;
            crc_reg     <= 16'hFFFF;
            count_reg   <= 16'd1;
          end else if (line_rise) begin
            state_reg <= S_DROP;
            o_err_ovr <= 1'b1;
          end
        end
        S_LINE: begin
          o_pkt_data  <= pipe_reg;
          o_pkt_valid <= 1'b1;
          crc_reg     <= crc_chain[8];
          if (i_pixel_valid) begin
            pipe_reg <= i_pixel_data;
            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
          end else begin
            state_reg <= S_TRAIL;
            if (count_reg != WORDS) o_err_len <= 1'b1;
          end
        end
        S_TRAIL: begin
          o_pkt_data  <= {48'd0, crc_reg};
          o_pkt_valid <= 1'b1;
          o_pkt_eop   <= 1'b1;
          // A new line arriving while the trailer is still going out cannot be framed.
          if (line_rise) begin
            state_reg <= S_DROP;
            o_err_ovr <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_DROP: begin
          if (line_fall) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
      if (!line_out && fe_req) begin
        o_pkt_data  <= short_word(6'h01, o_frame_num);
        o_pkt_valid <= 1'b1;
        o_pkt_sop   <= 1'b1;
        o_pkt_eop   <= 1'b1;
        fe_pend_reg <= 1'b0;
      end else if (!line_out && fs_req) begin
        o_pkt_data  <= short_word(6'h00, frame_next);
        o_pkt_valid <= 1'b1;
        o_pkt_sop   <= 1'b1;
        o_pkt_eop   <= 1'b1;
        o_frame_num <= frame_next;
        fs_pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csi2_pkt_framer.sv
// Bench for csi2_pkt_framer: per-cycle stimulus scenarios compared stamp by stamp
// against a packet-level reference model built from the framing rules.
module tb_csi2_pkt_framer;
  localparam int          HACT  = 16;
  localparam int          WORDS = HACT / 4;
  localparam logic [15:0] WC    = 16'd32;
  localparam int          MAXC  = 4096;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_hsync = 1'b0, i_vsync = 1'b0;
  logic [63:0] i_pixel_data = '0;
  logic        i_pixel_valid = 1'b0;
  logic [5:0]  i_data_type = '0;
  logic [63:0] o_pkt_data;
  logic        o_pkt_valid, o_pkt_sop, o_pkt_eop, o_err_len, o_err_ovr;
  logic [15:0] o_frame_num;

  csi2_pkt_framer #(.HACT(HACT), .BPP_BYTES(2), .VC(2'd0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid), .i_data_type(i_data_type),
    .o_pkt_data(o_pkt_data), .o_pkt_valid(o_pkt_valid), .o_pkt_sop(o_pkt_sop),
    .o_pkt_eop(o_pkt_eop), .o_frame_num(o_frame_num), .o_err_len(o_err_len),
    .o_err_ovr(o_err_ovr)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0, checks = 0;
  int edge_cnt = 0, base = 0, mon_idx = 0;
  bit rec_on = 1'b0;
  logic        rec_v [MAXC];
  logic [63:0] rec_d [MAXC];
  logic        rec_sop [MAXC];
  logic        rec_eop [MAXC];
  bit          exp_v [MAXC];
  logic [63:0] exp_d [MAXC];
  bit          exp_sop [MAXC];
  bit          exp_eop [MAXC];
  bit          stim_vs[$];
  bit          stim_pv[$];
  logic [63:0] stim_pd[$];
  logic [5:0]  stim_dt[$];
  bit          cur_vs = 1'b0;
  logic [15:0] m_frame = '0;
  bit          m_err_len = 1'b0, m_err_ovr = 1'b0;

  always @(posedge i_clk) edge_cnt = edge_cnt + 1;

  always @(negedge i_clk) begin
    if (rec_on) begin
      mon_idx = edge_cnt - base;
      if (mon_idx >= 0 && mon_idx < MAXC) begin
        rec_v[mon_idx]   = o_pkt_valid;
        rec_d[mon_idx]   = o_pkt_data;
        rec_sop[mon_idx] = o_pkt_sop;
        rec_eop[mon_idx] = o_pkt_eop;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [63:0] w);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int k = 0; k < 64; k++) begin
      fb = c[0] ^ w[k];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  function automatic logic [63:0] short_ref(input logic [7:0] di, input logic [15:0] field);
    return {32'd0, di ^ field[7:0] ^ field[15:8], field, di};
  endfunction

  function automatic void put(input int s, input logic [63:0] d, input bit sop, input bit eop);
    if (s >= 0 && s < MAXC) begin
      exp_v[s] = 1'b1; exp_d[s] = d; exp_sop[s] = sop; exp_eop[s] = eop;
    end
  endfunction

  task automatic model_run(input int n);
    bit pvs, ppv, in_line, vs, pv;
    int prev_fall, cnt, s, last;
    logic [15:0] crc;
    int sh_e[$];
    bit sh_fs[$];
    pvs = 0; ppv = 0; in_line = 0; prev_fall = -10; cnt = 0; crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      vs = stim_vs[i];
      pv = stim_pv[i];
      if (pv && !ppv) begin
        if (!vs || i == prev_fall + 1) m_err_ovr = 1'b1;
        else begin
          in_line = 1; cnt = 0; crc = 16'hFFFF;
          put(i, short_ref({2'b00, stim_dt[i]}, WC), 1, 0);
        end
      end
      if (in_line && pv) begin
        put(i + 1, stim_pd[i], 0, 0);
        crc = crc_ref(crc, stim_pd[i]);
        cnt++;
      end
      if (!pv && ppv && in_line) begin
        put(i + 1, {48'd0, crc}, 0, 1);
        if (cnt != WORDS) m_err_len = 1'b1;
        in_line = 0;
        prev_fall = i;
      end
      if (vs && !pvs) begin sh_e.push_back(i); sh_fs.push_back(1); end
      if (!vs && pvs) begin sh_e.push_back(i); sh_fs.push_back(0); end
      pvs = vs;
      ppv = pv;
    end
    // Short packets take the first cycle not used by a line.
    last = -1;
    for (int k = 0; k < sh_e.size(); k++) begin
      s = (sh_e[k] > last) ? sh_e[k] : last + 1;
      while (s < MAXC && exp_v[s]) s++;
      if (sh_fs[k]) begin
        m_frame = (m_frame == 16'hFFFF) ? 16'd1 : m_frame + 16'd1;
        put(s, short_ref(8'h00, m_frame), 1, 1);
      end else begin
        put(s, short_ref(8'h01, m_frame), 1, 1);
      end
      last = s;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_stim();
    stim_vs.delete(); stim_pv.delete(); stim_pd.delete(); stim_dt.delete();
  endtask

  task automatic push_cyc(input bit pv, input logic [63:0] d, input logic [5:0] dt);
    stim_vs.push_back(cur_vs); stim_pv.push_back(pv); stim_pd.push_back(d); stim_dt.push_back(dt);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(0, 64'd0, 6'd0);
  endtask

  task automatic push_line(input int n, input logic [5:0] dt);
    for (int i = 0; i < n; i++) push_cyc(1, {$urandom, $urandom}, dt);
  endtask

  // Drives the queued stimulus (history assumed 0), then checks every output stamp.
  task automatic run_scenario(input string name);
    int n, shown, pkts;
    n = stim_vs.size();
    for (int s = 0; s < MAXC; s++) begin
      rec_v[s] = 1'b0; rec_d[s] = '0; rec_sop[s] = 1'b0; rec_eop[s] = 1'b0;
      exp_v[s] = 1'b0; exp_d[s] = '0; exp_sop[s] = 1'b0; exp_eop[s] = 1'b0;
    end
    base = edge_cnt + 1;
    rec_on = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_vsync = stim_vs[i]; i_pixel_valid = stim_pv[i];
      i_pixel_data = stim_pd[i]; i_data_type = stim_dt[i];
      @(posedge i_clk); #1;
    end
    #5;
    rec_on = 1'b0;
    @(posedge i_clk); #1;
    model_run(n);
    shown = 0; pkts = 0;
    for (int s = 0; s < n; s++) begin
      checks++;
      if (rec_v[s] === 1'b1) pkts++;
      if (rec_v[s] !== exp_v[s] || (exp_v[s] && (rec_d[s] !== exp_d[s] ||
          rec_sop[s] !== exp_sop[s] || rec_eop[s] !== exp_eop[s]))) begin
        errors++;
        if (shown < 20)
          $display("FAIL %s stamp %0d: got v=%b d=%h sop=%b eop=%b, expected v=%b d=%h sop=%b eop=%b",
                   name, s, rec_v[s], rec_d[s], rec_sop[s], rec_eop[s],
                   exp_v[s], exp_d[s], exp_sop[s], exp_eop[s]);
        shown++;
      end
    end
    checks++;
    if (o_frame_num !== m_frame) begin
      errors++; $display("FAIL %s frame_num: got %h expected %h", name, o_frame_num, m_frame);
    end
    checks++;
    if (o_err_len !== m_err_len) begin
      errors++; $display("FAIL %s err_len: got %b expected %b", name, o_err_len, m_err_len);
    end
    checks++;
    if (o_err_ovr !== m_err_ovr) begin
      errors++; $display("FAIL %s err_ovr: got %b expected %b", name, o_err_ovr, m_err_ovr);
    end
    $display("scenario %s: %0d cycles, %0d packet words, frame %0d", name, n, pkts, o_frame_num);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (o_pkt_valid !== 1'b0 || o_pkt_sop !== 1'b0 || o_pkt_eop !== 1'b0 || o_pkt_data !== 64'd0) begin
      errors++;
      $display("FAIL %s pkt outputs: got v=%b sop=%b eop=%b d=%h expected all 0",
               name, o_pkt_valid, o_pkt_sop, o_pkt_eop, o_pkt_data);
    end
    checks++;
    if (o_frame_num !== 16'd0 || o_err_len !== 1'b0 || o_err_ovr !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got frame=%h len=%b ovr=%b expected 0 0 0",
               name, o_frame_num, o_err_len, o_err_ovr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset");
    i_rst = 1'b0;
    m_frame = '0; m_err_len = 0; m_err_ovr = 0;
  endtask

  task automatic test_frame();
    clear_stim();
    cur_vs = 1; push_idle(3); push_line(4, 6'h2E); push_idle(12); push_line(4, 6'h2E); push_idle(12);
    cur_vs = 0; push_idle(8);
    run_scenario("frame");
    checks++;
    if (rec_d[0] !== 64'h0000_0000_0100_0100 || rec_sop[0] !== 1'b1 || rec_eop[0] !== 1'b1) begin
      errors++; $display("FAIL fs_word: got %h sop=%b eop=%b expected 0000000001000100 1 1", rec_d[0], rec_sop[0], rec_eop[0]);
    end
    checks++;
    if (rec_d[3] !== 64'h0000_0000_0E00_202E || rec_sop[3] !== 1'b1) begin
      errors++; $display("FAIL header_word: got %h sop=%b expected 000000000e00202e 1", rec_d[3], rec_sop[3]);
    end
    checks++;
    if (rec_eop[8] !== 1'b1 || rec_v[9] !== 1'b0 || rec_sop[19] !== 1'b1) begin
      errors++; $display("FAIL line_timing: got eop8=%b v9=%b sop19=%b expected 1 0 1", rec_eop[8], rec_v[9], rec_sop[19]);
    end
    checks++;
    if (rec_d[35] !== 64'h0000_0000_0000_0101 || rec_eop[35] !== 1'b1) begin
      errors++; $display("FAIL fe_word: got %h eop=%b expected 0000000000000101 1", rec_d[35], rec_eop[35]);
    end
  endtask

  task automatic test_crc_len();
    clear_stim();
    cur_vs = 1; push_idle(3);
    push_cyc(1, 64'h72F3_DCB9_0200_00FF, 6'h2E);
    push_cyc(1, 64'h7CC2_75C8_5AB8_D4BB, 6'h2E);
    push_cyc(1, 64'h0100_00FF_DF05_F881, 6'h2E);
    push_idle(4); cur_vs = 0; push_idle(8);
    run_scenario("crc_short_line");
    checks++;
    if (rec_d[7] !== 64'h0000_0000_0000_00F0 || rec_eop[7] !== 1'b1) begin
      errors++; $display("FAIL crc_vector: got %h eop=%b expected 00000000000000f0 1", rec_d[7], rec_eop[7]);
    end
    clear_stim();
    cur_vs = 1; push_idle(3); push_line(4, 6'h2B); push_idle(5); cur_vs = 0; push_idle(8);
    run_scenario("len_sticky");
    checks++;
    if (o_err_len !== 1'b1) begin
      errors++; $display("FAIL err_len_sticky: got %b expected 1", o_err_len);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (o_err_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_before: got %b expected 0", o_err_ovr);
    end
    clear_stim();
    cur_vs = 1; push_idle(3); push_line(4, 6'h2E); push_idle(1); push_line(4, 6'h2E);
    push_idle(3); push_line(4, 6'h2E); push_idle(3);
    cur_vs = 0; push_idle(3); push_line(4, 6'h2E); push_idle(8);
    run_scenario("overrun");
    checks++;
    if (rec_v[9] !== 1'b0 || rec_v[15] !== 1'b1) begin
      errors++; $display("FAIL dropped_line: got v9=%b v15=%b expected 0 1", rec_v[9], rec_v[15]);
    end
  endtask

  task automatic test_fe_collision();
    clear_stim();
    cur_vs = 1; push_idle(3); push_line(4, 6'h12); push_idle(1); cur_vs = 0; push_idle(8);
    run_scenario("fe_collision");
    checks++;
    if (rec_eop[8] !== 1'b1 || rec_d[8][63:16] !== 48'd0 || rec_v[9] !== 1'b1 || rec_d[9][7:0] !== 8'h01) begin
      errors++; $display("FAIL fe_after_crc: got eop8=%b d8=%h v9=%b di9=%h expected 1 crc-word 1 01",
                         rec_eop[8], rec_d[8], rec_v[9], rec_d[9][7:0]);
    end
  endtask

  task automatic test_frame_count();
    clear_stim();
    for (int f = 0; f < 300; f++) begin
      cur_vs = 1; push_idle(2); cur_vs = 0; push_idle(2);
    end
    push_idle(8);
    run_scenario("frame_count");
  endtask

  task automatic test_random();
    int nl, len;
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int f = 0; f < 4; f++) begin
        cur_vs = 0; push_idle($urandom_range(4, 2));
        cur_vs = 1; push_idle($urandom_range(5, 2));
        nl = $urandom_range(4, 1);
        for (int l = 0; l < nl; l++) begin
          len = ($urandom_range(9, 0) < 8) ? WORDS : $urandom_range(6, 2);
          push_line(len, 6'($urandom_range(63, 0)));
          push_idle(($urandom_range(9, 0) == 0) ? 1 : $urandom_range(6, 2));
        end
      end
      cur_vs = 0; push_idle(8);
      run_scenario("random");
    end
  endtask

  task automatic test_reset_mid();
    i_vsync = 1; i_pixel_valid = 0;
    repeat (3) @(posedge i_clk);
    #1;
    i_pixel_valid = 1;
    for (int i = 0; i < 3; i++) begin
      i_pixel_data = {$urandom, $urandom};
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_idle_outputs("reset_mid");
    i_rst = 1'b0;
    m_frame = '0; m_err_len = 0; m_err_ovr = 0;
    clear_stim();
    cur_vs = 1; push_idle(3); push_line(4, 6'h2E); push_idle(4); cur_vs = 0; push_idle(8);
    run_scenario("after_reset");
    checks++;
    if (rec_d[0] !== 64'h0000_0000_0100_0100 || rec_d[3] !== 64'h0000_0000_0E00_202E) begin
      errors++; $display("FAIL clean_restart: got fs=%h hdr=%h expected 0000000001000100 000000000e00202e", rec_d[0], rec_d[3]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_crc_len();
    test_overrun();
    test_fe_collision();
    test_frame_count();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
